uart_tx: RTL and testbench

- UART transmitter: serialises a parallel word onto a single `tx` line as 8N1-style frames.
- Frame: 1 start bit (0), BIT_WIDTH data bits LSB first, 1 stop bit (1); optional parity.
- Counterpart of the team's UART receiver; same baud parameterisation, so a loopback of `tx` into the receiver decodes the same word.
- Sits between a byte-producing client (valid/ready handshake) and the board TX pin.

---
 rtl/uart_tx.sv | 144 ++++++++++++++
 tb/tb_uart_tx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, BIT_WIDTH data bits LSB first, optional even parity, stop bit.
// Define UART_TX_PARITY_EN to insert the even-parity bit between the data bits and the stop bit.
module uart_tx #(
  parameter int unsigned CLOCK_BAUD_RATIO = 400,
  parameter int unsigned BIT_WIDTH        = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_WIDTH-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 done
);

  localparam int unsigned BAUD_W = $clog2(CLOCK_BAUD_RATIO);
  localparam int unsigned CNT_W  = $clog2(BIT_WIDTH + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCK_BAUD_RATIO - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(BIT_WIDTH - 1);

  if (CLOCK_BAUD_RATIO < 2) begin : g_bad_ratio
    $error("uart_tx: CLOCK_BAUD_RATIO must be >= 2");
  end
  if (BIT_WIDTH < 1) begin : g_bad_width
    $error("uart_tx: BIT_WIDTH must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [CNT_W-1:0]     bit_q, bit_d;
  logic [BIT_WIDTH-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  logic baud_last;
  assign baud_last = (baud_q == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_last ? '0 : baud_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (valid) begin
          state_d  = S_START;
          shift_d  = data;
`ifdef UART_TX_PARITY_EN
          // Parity is latched here because the shift register is consumed while sending.
          parity_d = ^data;
`endif
        end
      end
      S_START: begin
        if (baud_last) state_d = S_BIT;
      end
      S_BIT: begin
        if (baud_last) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_last) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (baud_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // tx/done are decoded from next-state values so the registered outputs line up with state_q.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_BIT:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
    done_d = (state_d == S_STOP) && (baud_d == BAUD_LAST);
  end

  assign ready = (state_q == S_IDLE);
  assign tx    = tx_q;
  assign done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: drivers push expected frames, a negedge monitor decodes tx and compares.
// Define UART_TX_PARITY_EN for both RTL and bench to exercise the parity bit.
module tb_uart_tx;
  localparam int unsigned R  = 4;
  localparam int unsigned BW = 8;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NB = BW + 3;
`else
  localparam int unsigned NB = BW + 2;
`endif
  localparam int unsigned FL = NB * R;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic          ready;
  logic          tx;
  logic          done;
  logic [BW-1:0] data;

  uart_tx #(.CLOCK_BAUD_RATIO(R), .BIT_WIDTH(BW)) dut (
    .clk  (clk),
    .rst  (rst),
    .data (data),
    .valid(valid),
    .ready(ready),
    .tx   (tx),
    .done (done)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_seen = 1'b1;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [NB-1:0] frame;
    int            start;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  task automatic note_fail(input string name);
    n_checks++;
    $display("FAIL %s: event seen, none required", name);
  endtask

  // Frame in transmission order, bit 0 first; par is the hand-computed even parity of w.
  function automatic logic [NB-1:0] frame_of(input logic [BW-1:0] w, input logic par);
`ifdef UART_TX_PARITY_EN
    return {1'b1, par, w, 1'b0};
`else
    return {1'b1, w, 1'b0};
`endif
  endfunction

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic send(input logic [BW-1:0] w, input logic par, input logic keep, output int acc);
    int   n;
    exp_t e;
    data  = w;
    valid = 1'b1;
    n = 0;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      note_fail("accept_timeout");
      valid = 1'b0;
      acc   = -1;
    end else begin
      acc     = cyc + 1;
      e.frame = frame_of(w, par);
      e.start = acc;
      sb.push_back(e);
      @(negedge clk);
      if (!keep) valid = 1'b0;
    end
  endtask

  // Monitor
  logic          capturing = 1'b0;
  logic          rdy_chk   = 1'b0;
  int            idx;
  exp_t          cur;
  logic [FL-1:0] tx_v, done_v, rdy_v, exp_tx, exp_done;

  always @(negedge clk) begin
    if (rst_seen) begin
      capturing = 1'b0;
      rdy_chk   = 1'b0;
    end else begin
      if (!capturing) begin
        if (rdy_chk) begin
          check("ready_after_done", 64'(ready), 64'd1);
          rdy_chk = 1'b0;
        end
        if (done) note_fail("done_outside_frame");
        if (tx == 1'b0) begin
          if (sb.size() == 0) begin
            note_fail("unexpected_frame");
            cur.start = -1;
          end else begin
            cur = sb.pop_front();
            check("start_cycle", 64'(cyc), 64'(cur.start));
          end
          capturing = 1'b1;
          idx       = 0;
        end
      end
      if (capturing) begin
        tx_v[idx]   = tx;
        done_v[idx] = done;
        rdy_v[idx]  = ready;
        idx++;
        if (idx == FL) begin
          capturing = 1'b0;
          rdy_chk   = 1'b1;
          if (cur.start >= 0) begin
            for (int i = 0; i < FL; i++) exp_tx[i] = cur.frame[i / R];
            exp_done = '0;
            exp_done[FL-1] = 1'b1;
            check("tx_pattern", 64'(tx_v), 64'(exp_tx));
            check("done_pattern", 64'(done_v), 64'(exp_done));
            check("ready_in_frame", 64'(rdy_v), 64'd0);
          end
        end
      end
    end
  end

  initial begin
    int acc, acc2, n;
    rst   = 1'b1;
    valid = 1'b1;
    data  = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    rst   = 1'b0;
    valid = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_tx", 64'(tx), 64'd1);
    check("idle_ready", 64'(ready), 64'd1);

    // 0xA5: bits 1,0,1,0,0,1,0,1, parity 0
    send(8'hA5, 1'b0, 1'b0, acc);

    // Same word; data scrambled after acceptance and valid held through the frame
    send(8'hA5, 1'b0, 1'b1, acc);
    data = 8'h00;
    n = 0;
    while (cyc < acc + FL - 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    valid = 1'b0;

    // Back-to-back: valid never drops between the two words
    send(8'h00, 1'b0, 1'b1, acc);
    send(8'hFF, 1'b0, 1'b0, acc2);
    check("b2b_spacing", 64'(acc2 - acc), 64'(FL + 1));

    // Abort in the middle of data bit 3
    send(8'h5A, 1'b0, 1'b0, acc);
    n = 0;
    while (cyc < acc + 4 * R + 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_tx", 64'(tx), 64'd1);
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_done", 64'(done), 64'd0);
    repeat (FL) @(negedge clk);
    check("abort_idle_tx", 64'(tx), 64'd1);

    // 0x3C: four ones, parity 0
    send(8'h3C, 1'b0, 1'b0, acc);

`ifdef UART_TX_PARITY_EN
    send(8'h07, 1'b1, 1'b0, acc);
    send(8'h03, 1'b0, 1'b0, acc);
`endif

    n = 0;
    while ((sb.size() != 0 || capturing || rdy_chk) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    check("monitor_idle", 64'(capturing), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
